// File: rtl/miter_mon_pkg.sv
// Shared definitions for the miter divergence monitor: run-state encoding,
// default parameter values and small bus-slicing helpers.
package miter_mon_pkg;

  // Default configuration of the monitor
  localparam int DEF_NUM_CH = 8;
  localparam int DEF_CH_W   = 32;
  localparam int DEF_DEPTH  = 3;
  localparam int DEF_CNT_W  = 16;

  // Run-control states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_WIN  = 2'd1,
    RUN_CONT = 2'd2,
    REPORT   = 2'd3
  } mon_state_e;

  // Bit offset of channel k inside a packed bus of ch_w-wide channels
  function automatic int ch_lsb(input int k, input int ch_w);
    return k * ch_w;
  endfunction

  // Width of a channel index, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/miter_ch_cmp.sv
// Masked channel comparator for the miter monitor. Flags every unmasked
// channel whose A and B values differ and encodes the lowest flagged index.
// Purely combinational.
module miter_ch_cmp
  import miter_mon_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int IDX_W  = idx_w(DEF_NUM_CH)
) (
  input  logic [NUM_CH*CH_W-1:0] ch_a,
  input  logic [NUM_CH*CH_W-1:0] ch_b,
  input  logic [NUM_CH-1:0]      mask,
  output logic [NUM_CH-1:0]      diff,
  output logic [IDX_W-1:0]       first_idx,
  output logic                   any_diff
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign diff[k] = (ch_a[ch_lsb(k, CH_W) +: CH_W] != ch_b[ch_lsb(k, CH_W) +: CH_W])
                     && !mask[k];
  end

  assign any_diff = |diff;

  // Lowest-index priority encode: scan downward so the smallest set index wins
  always_comb begin
    first_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      first_idx = diff[k] ? IDX_W'(k) : first_idx;
    end
  end

endmodule

// File: rtl/miter_window_monitor.sv
// Divergence monitor for a two-instance miter. After a start trigger it
// compares NUM_CH channel buses of instance A against instance B, either for
// a bounded window of DEPTH steps or until stop_i, and records sticky
// per-channel divergence plus the channel and step of the first divergence.
// Optional build macro MITER_MON_HIST_EN adds per-channel first-divergence
// step history with a registered read port (rd_ch_i / hist_step_o).
module miter_window_monitor
  import miter_mon_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int CH_W   = DEF_CH_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int IDX_W  = idx_w(NUM_CH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic                   stop_i,
  input  logic [NUM_CH-1:0]      ch_mask_i,
  input  logic [NUM_CH*CH_W-1:0] ch_a_i,
  input  logic [NUM_CH*CH_W-1:0] ch_b_i,
`ifdef MITER_MON_HIST_EN
  input  logic [IDX_W-1:0]       rd_ch_i,
  output logic [CNT_W-1:0]       hist_step_o,
`endif
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [NUM_CH-1:0]      diverge_o,
  output logic [IDX_W-1:0]       first_ch_o,
  output logic [CNT_W-1:0]       first_cycle_o,
  output logic [CNT_W-1:0]       step_o
);

  localparam logic [CNT_W-1:0] STEP_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(DEPTH);

  // The run state itself records the mode latched at start
  mon_state_e         state_r;
  logic [NUM_CH-1:0]  mask_r;
  logic [NUM_CH-1:0]  diverge_r;
  logic [IDX_W-1:0]   first_ch_r;
  logic [CNT_W-1:0]   first_cycle_r;
  logic [CNT_W-1:0]   step_r;
  logic               busy_r;
  logic               done_r;
  logic               pass_r;

  logic [NUM_CH-1:0]  diff_s;
  logic [NUM_CH-1:0]  diverge_nx_s;
  logic [IDX_W-1:0]   first_idx_s;
  logic               any_diff_s;
  logic [CNT_W-1:0]   step_inc_s;
  logic               run_s;
  logic               start_ok_s;
  logic               run_end_s;

  miter_ch_cmp #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .ch_a      (ch_a_i),
    .ch_b      (ch_b_i),
    .mask      (mask_r),
    .diff      (diff_s),
    .first_idx (first_idx_s),
    .any_diff  (any_diff_s)
  );

  // Step increment (saturating), run qualifiers and accumulated divergence
  always_comb begin
    step_inc_s   = (step_r == STEP_MAX) ? step_r : step_r + {{(CNT_W-1){1'b0}}, 1'b1};
    run_s        = (state_r == RUN_WIN) || (state_r == RUN_CONT);
    start_ok_s   = start_i && ((state_r == IDLE) || (state_r == REPORT));
    diverge_nx_s = diverge_r | diff_s;
    if (state_r == RUN_WIN) begin
      run_end_s = (step_inc_s == STEP_LAST);
    end else if (state_r == RUN_CONT) begin
      run_end_s = stop_i;
    end else begin
      run_end_s = 1'b0;
    end
  end

  // Run-control FSM with registered result outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      mask_r        <= '0;
      diverge_r     <= '0;
      first_ch_r    <= '0;
      first_cycle_r <= '0;
      step_r        <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b1;
    end else if (start_ok_s) begin
      state_r       <= mode_i ? RUN_CONT : RUN_WIN;
      mask_r        <= ch_mask_i;
      diverge_r     <= '0;
      first_ch_r    <= '0;
      first_cycle_r <= '0;
      step_r        <= '0;
      busy_r        <= 1'b1;
      done_r        <= 1'b0;
      pass_r        <= 1'b1;
    end else begin
      case (state_r)
        RUN_WIN, RUN_CONT: begin
          step_r    <= step_inc_s;
          diverge_r <= diverge_nx_s;
          pass_r    <= ~|diverge_nx_s;
          // First divergence is latched only while nothing has diverged yet
          if (any_diff_s && !(|diverge_r)) begin
            first_ch_r    <= first_idx_s;
            first_cycle_r <= step_inc_s;
          end
          if (run_end_s) begin
            state_r <= REPORT;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        REPORT: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign pass_o        = pass_r;
  assign diverge_o     = diverge_r;
  assign first_ch_o    = first_ch_r;
  assign first_cycle_o = first_cycle_r;
  assign step_o        = step_r;

`ifdef MITER_MON_HIST_EN
  logic [CNT_W-1:0] hist_r [NUM_CH];
  logic [CNT_W-1:0] hist_step_r;

  // Per-channel first-divergence step capture and registered history read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        hist_r[k] <= '0;
      end
      hist_step_r <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (start_ok_s) begin
          hist_r[k] <= '0;
        end else if (run_s && diff_s[k] && !diverge_r[k]) begin
          hist_r[k] <= step_inc_s;
        end
      end
      hist_step_r <= (int'(rd_ch_i) < NUM_CH) ? hist_r[rd_ch_i] : '0;
    end
  end

  assign hist_step_o = hist_step_r;
`endif

endmodule

// File: tb/tb_miter_window_monitor.sv
// Scoreboard bench for miter_window_monitor: each run pushes its expected
// report; a negedge monitor pops and compares whenever done_o is seen.
module tb_miter_window_monitor;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 32;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 4;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   start_i = 1'b0;
  logic                   mode_i = 1'b0;
  logic                   stop_i = 1'b0;
  logic [NUM_CH-1:0]      ch_mask_i = '0;
  logic [NUM_CH*CH_W-1:0] ch_a_i = '0;
  logic [NUM_CH*CH_W-1:0] ch_b_i = '0;
  logic                   busy_o;
  logic                   done_o;
  logic                   pass_o;
  logic [NUM_CH-1:0]      diverge_o;
  logic [2:0]             first_ch_o;
  logic [CNT_W-1:0]       first_cycle_o;
  logic [CNT_W-1:0]       step_o;
`ifdef MITER_MON_HIST_EN
  logic [2:0]             rd_ch_i = 3'd0;
  logic [CNT_W-1:0]       hist_step_o;
`endif

  typedef struct {
    logic       pass;
    logic [7:0] div;
    logic [2:0] fch;
    logic [3:0] fcyc;
    logic [3:0] step;
    int         done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  miter_window_monitor #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .stop_i        (stop_i),
    .ch_mask_i     (ch_mask_i),
    .ch_a_i        (ch_a_i),
    .ch_b_i        (ch_b_i),
`ifdef MITER_MON_HIST_EN
    .rd_ch_i       (rd_ch_i),
    .hist_step_o   (hist_step_o),
`endif
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pass_o        (pass_o),
    .diverge_o     (diverge_o),
    .first_ch_o    (first_ch_o),
    .first_cycle_o (first_cycle_o),
    .step_o        (step_o)
  );

  always #5 clock = ~clock;

  // Count rising edges so done timing can be checked
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Channel k of A gets a tag-dependent value; B differs on channels set in d
  task automatic drive_chans(input logic [7:0] d, input int tag);
    logic [31:0] v;
    for (int k = 0; k < NUM_CH; k++) begin
      v = 32'hC0DE_0000 | (32'(tag) << 8) | 32'(k);
      ch_a_i[k*CH_W +: CH_W] = v;
      ch_b_i[k*CH_W +: CH_W] = d[k] ? (v ^ 32'h0000_8001) : v;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      start_i = 1'b0;
      stop_i  = 1'b0;
      drive_chans(8'hFF, 90 + i);
    end
  endtask

  // Window run: d1..d3 are per-step difference patterns, inputs at the start
  // edge all differ but must not be compared
  task automatic run_window(input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                            input logic [7:0] mask, input logic pulse_start,
                            input logic e_pass, input logic [7:0] e_div,
                            input logic [2:0] e_fch, input logic [3:0] e_fcyc);
    exp_t e;
    @(negedge clock);
    start_i = 1'b1; mode_i = 1'b0; stop_i = 1'b0; ch_mask_i = mask;
    drive_chans(8'hFF, 0);
    e.pass = e_pass; e.div = e_div; e.fch = e_fch; e.fcyc = e_fcyc;
    e.step = 4'd3; e.done_cyc = cyc + 1 + DEPTH;
    exp_q.push_back(e);
    @(negedge clock);
    start_i = 1'b0; mode_i = 1'b1; ch_mask_i = ~mask; stop_i = 1'b1;
    drive_chans(d1, 1);
    @(negedge clock);
    chk("busy_in_window", 32'(busy_o), 32'd1);
    start_i = pulse_start; stop_i = 1'b0;
    drive_chans(d2, 2);
    @(negedge clock);
    start_i = 1'b0;
    drive_chans(d3, 3);
  endtask

  // Continuous run with stop_i at step stop_step and one divergence event
  task automatic run_cont(input int stop_step, input int div_step, input logic [7:0] div_mask,
                          input logic e_pass, input logic [7:0] e_div, input logic [2:0] e_fch,
                          input logic [3:0] e_fcyc, input logic [3:0] e_step);
    exp_t e;
    @(negedge clock);
    start_i = 1'b1; mode_i = 1'b1; stop_i = 1'b0; ch_mask_i = 8'h00;
    drive_chans(8'hFF, 0);
    e.pass = e_pass; e.div = e_div; e.fch = e_fch; e.fcyc = e_fcyc;
    e.step = e_step; e.done_cyc = cyc + 1 + stop_step;
    exp_q.push_back(e);
    for (int s = 1; s <= stop_step; s++) begin
      @(negedge clock);
      start_i = 1'b0; mode_i = 1'b0;
      stop_i  = (s == stop_step);
      drive_chans((s == div_step) ? div_mask : 8'h00, s);
    end
  endtask

  // Scoreboard monitor: every done_o pulse must match the oldest expectation
  always @(negedge clock) begin
    exp_t e;
    if (reset && done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle",  32'(cyc),           32'(e.done_cyc));
        chk("pass",        32'(pass_o),        32'(e.pass));
        chk("diverge",     32'(diverge_o),     32'(e.div));
        chk("first_ch",    32'(first_ch_o),    32'(e.fch));
        chk("first_cycle", 32'(first_cycle_o), 32'(e.fcyc));
        chk("step",        32'(step_o),        32'(e.step));
        chk("busy_at_done", 32'(busy_o),       32'd0);
      end
    end
  end

  initial begin
    drive_chans(8'h00, 0);
    repeat (2) @(negedge clock);
    chk("rst_busy",   32'(busy_o),        32'd0);
    chk("rst_done",   32'(done_o),        32'd0);
    chk("rst_pass",   32'(pass_o),        32'd1);
    chk("rst_div",    32'(diverge_o),     32'd0);
    chk("rst_fch",    32'(first_ch_o),    32'd0);
    chk("rst_fcyc",   32'(first_cycle_o), 32'd0);
    chk("rst_step",   32'(step_o),        32'd0);
    reset = 1'b1;
    idle(2);

    // A == B throughout; stop_i in window ignored
    run_window(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 4'd0);
    // Channel 5 differs at step 2 only (back-to-back start from REPORT)
    run_window(8'h00, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0, 8'h20, 3'd5, 4'd2);
    idle(1);
    // Channels 2 and 6 at step 1, channel 0 at step 3
    run_window(8'h44, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 8'h45, 3'd2, 4'd1);
    idle(2);
    // Channel 5 masked; start pulsed mid-run must be ignored
    run_window(8'h00, 8'h20, 8'h00, 8'h20, 1'b1, 1'b1, 8'h00, 3'd0, 4'd0);
    idle(2);
    // Every channel masked, all differ
    run_window(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 3'd0, 4'd0);
    idle(2);
    // Continuous, 20 steps: step saturates at 15, divergence after saturation
    run_cont(20, 18, 8'h02, 1'b0, 8'h02, 3'd1, 4'd15, 4'd15);
    idle(2);
    // Continuous stopped at its first step
    run_cont(1, 1, 8'h80, 1'b0, 8'h80, 3'd7, 4'd1, 4'd1);
    idle(1);
    // Short continuous run without divergence
    run_cont(2, 0, 8'h00, 1'b1, 8'h00, 3'd0, 4'd0, 4'd2);
    idle(3);

    // Reset asserted during step 2 of a window run
    @(negedge clock);
    start_i = 1'b1; mode_i = 1'b0; ch_mask_i = 8'h00; drive_chans(8'hFF, 0);
    @(negedge clock);
    start_i = 1'b0; drive_chans(8'h08, 1);
    @(negedge clock);
    chk("pre_reset_div", 32'(diverge_o), 32'h08);
    drive_chans(8'h00, 2);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_busy", 32'(busy_o),        32'd0);
    chk("mid_rst_pass", 32'(pass_o),        32'd1);
    chk("mid_rst_div",  32'(diverge_o),     32'd0);
    chk("mid_rst_fcyc", 32'(first_cycle_o), 32'd0);
    chk("mid_rst_step", 32'(step_o),        32'd0);
    reset = 1'b1;
    idle(5);

`ifdef MITER_MON_HIST_EN
    // Channel 3 diverges at step 3; read back its first-divergence step
    run_window(8'h00, 8'h00, 8'h08, 8'h00, 1'b0, 1'b0, 8'h08, 3'd3, 4'd3);
    idle(2);
    @(negedge clock);
    rd_ch_i = 3'd3;
    @(negedge clock);
    chk("hist_ch3", 32'(hist_step_o), 32'd3);
    rd_ch_i = 3'd5;
    @(negedge clock);
    chk("hist_ch5", 32'(hist_step_o), 32'd0);
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
    chk("pending_reports", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
